// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between instruction fetch and load/store.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise LS has priority with an IF starvation override.
module dmem_port_arbiter #(
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_mask,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  localparam logic [3:0] LAT_INIT = 4'(READ_LAT);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic        if_win, ls_win, rd_done;

`ifdef DMEM_ARB_RR_EN
  owner_t last_q, last_d;
`else
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;
`endif

  // Grants are gated by rst so every output drops the moment reset asserts.
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (!rst && state_q == S_IDLE) begin
      if (if_req && ls_req) begin
`ifdef DMEM_ARB_RR_EN
        if_win = (last_q == OWN_LS);
`else
        if_win = (starve_q == STARVE_MAX);
`endif
        ls_win = !if_win;
      end else begin
        if_win = if_req;
        ls_win = ls_req;
      end
    end
  end

  always_comb begin
    if_gnt    = if_win;
    ls_gnt    = ls_win;
    mem_re    = if_win || (ls_win && !ls_we);
    mem_we    = ls_win && ls_we;
    mem_addr  = if_win ? if_addr : (ls_win ? ls_addr : 32'h0);
    mem_wdata = mem_we ? ls_wdata : 32'h0;
    mem_mask  = mem_we ? ls_mask : (mem_re ? 4'hF : 4'h0);
    rd_done   = (state_q == S_WAIT) && (lat_cnt_q == 4'd1);
    if_rvalid = rd_done && (owner_q == OWN_IF);
    ls_rvalid = rd_done && (owner_q == OWN_LS);
    if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    ls_rdata  = ls_rvalid ? mem_rdata : ls_rdata_q;
    busy      = (state_q == S_WAIT);
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lat_cnt_d  = lat_cnt_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (mem_re) begin
          state_d   = S_WAIT;
          lat_cnt_d = LAT_INIT;
          owner_d   = if_win ? OWN_IF : OWN_LS;
        end
      end
      S_WAIT: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        if (rd_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (if_rvalid) if_rdata_d = mem_rdata;
    if (ls_rvalid) ls_rdata_d = mem_rdata;
  end

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    last_d = last_q;
    if (if_win)      last_d = OWN_IF;
    else if (ls_win) last_d = OWN_LS;
  end
`else
  // A lost contention only counts while IF keeps asking; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_win)                   starve_d = 4'd0;
    else if (ls_win && starve_q != STARVE_MAX) starve_d = starve_q + 4'd1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IF;
      lat_cnt_q  <= 4'd0;
      if_rdata_q <= 32'h0;
      ls_rdata_q <= 32'h0;
`ifdef DMEM_ARB_RR_EN
      last_q     <= OWN_IF;
`else
      starve_q   <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lat_cnt_q  <= lat_cnt_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
`ifdef DMEM_ARB_RR_EN
      last_q     <= last_d;
`else
      starve_q   <= starve_d;
`endif
    end
  end

  a_if_gnt_req: assert property (@(posedge clk) disable iff (rst) if_gnt |-> if_req);
  a_ls_gnt_req: assert property (@(posedge clk) disable iff (rst) ls_gnt |-> ls_req);
  a_one_gnt:    assert property (@(posedge clk) disable iff (rst) !(if_gnt && ls_gnt));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: queued requesters, latency-modelled memory, per-cycle checks.
module tb_dmem_port_arbiter;
  localparam int READ_LAT     = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] ls_addr = '0, ls_wdata = '0;
  logic [3:0]  ls_mask = '0;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_mask;
  logic        busy;

  dmem_port_arbiter #(.READ_LAT(READ_LAT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_mask(ls_mask),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory macro: data appears READ_LAT cycles after a sampled mem_re, garbage otherwise.
  logic [31:0] rd_pipe [READ_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_re ? rom(mem_addr) : 32'hBAD0_BAD0;
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[READ_LAT-1];

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask;} ls_txn_t;
  typedef struct {logic is_ls; logic [31:0] data; int due;} exp_t;

  logic [31:0] if_q[$];
  ls_txn_t     ls_q[$];
  exp_t        sb[$];

  int n_checks = 0, n_fail = 0, cyc = 0;
  int m_wait = 0, m_starve = 0;
  logic m_last_ls = 1'b0;
  logic [31:0] last_if = '0, last_ls = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    logic exp_if, exp_ls, exp_re, exp_we, due, exp_irv, exp_lrv;
    logic [31:0] exp_addr;
    @(posedge clk); #1;
    if_req = (if_q.size() != 0);
    if_addr = '0;
    if (if_req) if_addr = if_q[0];
    ls_req = (ls_q.size() != 0);
    {ls_we, ls_addr, ls_wdata, ls_mask} = '0;
    if (ls_req) {ls_we, ls_addr, ls_wdata, ls_mask} = ls_q[0];
    @(negedge clk);
    exp_if = 1'b0;
    exp_ls = 1'b0;
    if (m_wait == 0) begin
      if (if_req && ls_req) begin
`ifdef DMEM_ARB_RR_EN
        exp_if = m_last_ls;
`else
        exp_if = (m_starve >= STARVE_LIMIT);
`endif
        exp_ls = !exp_if;
      end else begin
        exp_if = if_req;
        exp_ls = ls_req;
      end
    end
    exp_re   = exp_if || (exp_ls && !ls_we);
    exp_we   = exp_ls && ls_we;
    exp_addr = exp_if ? if_addr : ls_addr;
    check_val("if_gnt", if_gnt, exp_if);
    check_val("ls_gnt", ls_gnt, exp_ls);
    check_val("mem_re", mem_re, exp_re);
    check_val("mem_we", mem_we, exp_we);
    check_val("busy", busy, m_wait > 0);
    if (exp_re || exp_we) begin
      check_val("mem_addr", mem_addr, exp_addr);
      check_val("mem_mask", mem_mask, exp_we ? ls_mask : 4'hF);
      if (exp_we) check_val("mem_wdata", mem_wdata, ls_wdata);
    end
    due = (sb.size() != 0) && (sb[0].due == cyc);
    exp_irv = due && !sb[0].is_ls;
    exp_lrv = due && sb[0].is_ls;
    check_val("if_rvalid", if_rvalid, exp_irv);
    check_val("ls_rvalid", ls_rvalid, exp_lrv);
    if (exp_irv) last_if = sb[0].data;
    if (exp_lrv) last_ls = sb[0].data;
    if (due) void'(sb.pop_front());
    check_val("if_rdata", if_rdata, last_if);
    check_val("ls_rdata", ls_rdata, last_ls);
    if (exp_if) void'(if_q.pop_front());
    if (exp_ls) void'(ls_q.pop_front());
    if (exp_re) begin
      sb.push_back('{is_ls: exp_ls, data: rom(exp_addr), due: cyc + READ_LAT});
      m_wait = READ_LAT;
    end else if (m_wait > 0) begin
      m_wait--;
    end
    if (!if_req || exp_if) m_starve = 0;
    else if (exp_ls && m_starve < STARVE_LIMIT) m_starve++;
    if (exp_if) m_last_ls = 1'b0;
    else if (exp_ls) m_last_ls = 1'b1;
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((if_q.size() != 0 || ls_q.size() != 0 || m_wait != 0 || sb.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check_val("drain_in_budget", {31'b0, n < budget}, 32'd1);
  endtask

  // Asserts rst part-way through a cycle with both requests high; outputs must clear at once.
  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h80;
    #1;
    check_val("rst_if_gnt", if_gnt, 0);
    check_val("rst_ls_gnt", ls_gnt, 0);
    check_val("rst_mem_re", mem_re, 0);
    check_val("rst_mem_we", mem_we, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_mask", mem_mask, 0);
    check_val("rst_mem_wdata", mem_wdata, 0);
    check_val("rst_if_rvalid", if_rvalid, 0);
    check_val("rst_ls_rvalid", ls_rvalid, 0);
    check_val("rst_if_rdata", if_rdata, 0);
    check_val("rst_ls_rdata", ls_rdata, 0);
    check_val("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    if_req = 1'b0;
    ls_req = 1'b0;
    sb.delete();
    m_wait = 0; m_starve = 0; m_last_ls = 1'b0;
    last_if = '0; last_ls = '0;
  endtask

  initial begin
    pulse_reset();

    if_q.push_back(32'h100);
    drain(20);

    ls_q.push_back('{we: 1'b1, addr: 32'h200, wdata: 32'h0000_00AA, mask: 4'b0001});
    ls_q.push_back('{we: 1'b1, addr: 32'h204, wdata: 32'h00BB_CC00, mask: 4'b0110});
    ls_q.push_back('{we: 1'b1, addr: 32'h208, wdata: 32'hDEAD_BEEF, mask: 4'b1111});
    drain(20);

    for (int i = 0; i < 10; i++)
      ls_q.push_back('{we: 1'b1, addr: 32'h300 + 4*i, wdata: 32'h5000_0000 + i, mask: 4'hF});
    if_q.push_back(32'h400);
    if_q.push_back(32'h404);
    drain(60);

    for (int i = 0; i < 3; i++) begin
      if_q.push_back(32'h500 + 4*i);
      ls_q.push_back('{we: 1'b0, addr: 32'h600 + 4*i, wdata: 32'h0, mask: 4'hF});
    end
    drain(60);

    ls_q.push_back('{we: 1'b0, addr: 32'h700, wdata: 32'h0, mask: 4'hF});
    step();
    if_q.push_back(32'h800);
    pulse_reset();
    drain(20);
    repeat (READ_LAT + 2) step();

    for (int c = 0; c < 300; c++) begin
      if (if_q.size() < 3 && $urandom_range(0, 2) == 0)
        if_q.push_back($urandom() & 32'hFFFF_FFFC);
      if (ls_q.size() < 3 && $urandom_range(0, 1) == 0)
        ls_q.push_back('{we: 1'($urandom_range(0, 1)), addr: $urandom() & 32'hFFFF_FFFC,
                         wdata: $urandom(), mask: 4'($urandom_range(1, 15))});
      step();
    end
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
